// File: rtl/cache_pkg.sv
// Shared widths, FSM state encoding and address/word helpers for sram_cache.
package cache_pkg;

    localparam int unsigned IDX_W  = 6;
    localparam int unsigned TAG_W  = 9;
    localparam int unsigned BLK_W  = 64;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned SA_W   = 18;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_WR
    } state_t;

    // Cacheable byte address split into its fields, MSB first.
    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [IDX_W-1:0] idx;
        logic             word;
        logic [1:0]       byte_off;
    } addr_t;

    function automatic addr_t split_addr(input logic [SA_W-1:0] a);
        return addr_t'(a);
    endfunction

    // Select the low (sel=0) or high (sel=1) word of a block.
    function automatic logic [WORD_W-1:0] blk_word(input logic [BLK_W-1:0] blk, input logic sel);
        return sel ? blk[BLK_W-1:WORD_W] : blk[WORD_W-1:0];
    endfunction

endpackage

// File: rtl/cache_way.sv
// One cache way: per-set data block, tag and valid bit.
// Ports: idx/tag select and compare (async read: valid, hit, blk);
//        fill writes block+tag+valid; word_we writes one word of the block;
//        rst (active-low, async) clears only the valid bits.
module cache_way
    import cache_pkg::*;
#(
    parameter int unsigned SETS     = 64,
    parameter int unsigned TAG_BITS = 9,
    parameter int unsigned IW       = $clog2(SETS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IW-1:0]       idx,
    input  logic [TAG_BITS-1:0] tag,
    input  logic                fill,
    input  logic [BLK_W-1:0]    fill_data,
    input  logic                word_we,
    input  logic                word_sel,
    input  logic [WORD_W-1:0]   word_data,
    output logic                valid,
    output logic                hit,
    output logic [BLK_W-1:0]    blk
);

    logic [SETS-1:0]     valid_q;
    logic [TAG_BITS-1:0] tag_q  [SETS];
    logic [BLK_W-1:0]    data_q [SETS];

    // Valid bits: the only per-way state cleared by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
        end else if (fill) begin
            valid_q[idx] <= 1'b1;
        end
    end

    // Tag/data storage, left unreset; a set is meaningless until its valid bit is set.
    always_ff @(posedge clk) begin
        if (fill) begin
            tag_q[idx]  <= tag;
            data_q[idx] <= fill_data;
        end else if (word_we) begin
            if (word_sel) begin
                data_q[idx][BLK_W-1:WORD_W] <= word_data;
            end else begin
                data_q[idx][WORD_W-1:0] <= word_data;
            end
        end
    end

    assign valid = valid_q[idx];
    assign hit   = valid_q[idx] && (tag_q[idx] == tag);
    assign blk   = data_q[idx];

endmodule

// File: rtl/sram_cache.sv
// Two-way set-associative, write-through, read-allocate cache in front of a
// 64-bit-read SRAM controller.
// Ports: MEM side  - address, wdata, MEM_R_EN, MEM_W_EN in; rdata, ready out.
//        SRAM side - sram_address, sram_wdata, sram_r_en, sram_w_en out;
//                    sram_rdata, sram_ready in.
// rdata/ready are combinational so read hits complete with no stall.
module sram_cache #(
    parameter int unsigned SETS  = 64,
    parameter int unsigned TAG_W = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    output logic [31:0] rdata,
    output logic        ready,
    output logic [17:0] sram_address,
    output logic [31:0] sram_wdata,
    output logic        sram_r_en,
    output logic        sram_w_en,
    input  logic [63:0] sram_rdata,
    input  logic        sram_ready
);
    import cache_pkg::*;

    state_t            state_q;
    state_t            state_d;
    logic [SETS-1:0]   lru_q;
    logic              lru_we;
    logic              lru_d;
    addr_t             req;
    logic              unused_bits;

    logic [1:0]        way_hit;
    logic [1:0]        way_valid;
    logic [1:0]        way_fill;
    logic [1:0]        way_wwe;
    logic [BLK_W-1:0]  way_blk [2];
    logic              hit;
    logic [BLK_W-1:0]  hit_blk;
    logic              victim;

    assign req         = split_addr(address[SA_W-1:0]);
    assign unused_bits = ^{address[31:SA_W], req.byte_off};

    // Both ways look up the same set; the address is held stable while busy.
    for (genvar w = 0; w < 2; w++) begin : g_way
        cache_way #(
            .SETS     (SETS),
            .TAG_BITS (TAG_W),
            .IW       (IDX_W)
        ) u_way (
            .clk       (clk),
            .rst       (rst),
            .idx       (req.idx),
            .tag       (req.tag),
            .fill      (way_fill[w]),
            .fill_data (sram_rdata),
            .word_we   (way_wwe[w]),
            .word_sel  (req.word),
            .word_data (wdata),
            .valid     (way_valid[w]),
            .hit       (way_hit[w]),
            .blk       (way_blk[w])
        );
    end

    assign hit     = |way_hit;
    assign hit_blk = way_hit[1] ? way_blk[1] : way_blk[0];
    // Fill an empty way first (way0 preferred), otherwise evict the LRU way.
    assign victim  = !way_valid[0] ? 1'b0 :
                     !way_valid[1] ? 1'b1 : lru_q[req.idx];

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // LRU bit per set names the way to evict next.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lru_q <= '0;
        end else if (lru_we) begin
            lru_q[req.idx] <= lru_d;
        end
    end

    // Next state, array update strobes and MEM-side response.
    always_comb begin
        state_d  = state_q;
        ready    = 1'b0;
        rdata    = '0;
        way_fill = '0;
        way_wwe  = '0;
        lru_we   = 1'b0;
        lru_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (MEM_W_EN) begin
                    state_d = S_WR;
                end else if (MEM_R_EN) begin
                    if (hit) begin
                        ready  = 1'b1;
                        rdata  = blk_word(hit_blk, req.word);
                        lru_we = 1'b1;
                        lru_d  = way_hit[0];
                    end else begin
                        state_d = S_RD;
                    end
                end else begin
                    ready = 1'b1;
                end
            end
            S_RD: begin
                if (sram_ready) begin
                    ready            = 1'b1;
                    rdata            = blk_word(sram_rdata, req.word);
                    way_fill[victim] = 1'b1;
                    lru_we           = 1'b1;
                    lru_d            = ~victim;
                    state_d          = S_IDLE;
                end
            end
            S_WR: begin
                if (sram_ready) begin
                    ready   = 1'b1;
                    way_wwe = way_hit;
                    lru_we  = hit;
                    lru_d   = way_hit[0];
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // SRAM strobes decode straight from the registered state.
    assign sram_r_en    = (state_q == S_RD);
    assign sram_w_en    = (state_q == S_WR);
    assign sram_address = (state_q == S_RD) ? {req.tag, req.idx, 3'b000} : address[SA_W-1:0];
    assign sram_wdata   = wdata;

endmodule

// File: tb/tb_sram_cache.sv
// Scoreboard bench for sram_cache: the driver queues the expected response of
// each MEM request, a monitor pops and checks it when the request completes.
module tb_sram_cache;

    localparam int K_HIT = 0;
    localparam int K_RD  = 1;
    localparam int K_WR  = 2;
    localparam int LAT   = 3;

    typedef struct {
        string       name;
        logic [31:0] rdata;
        int          kind;
        logic [17:0] sa;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] address;
    logic [31:0] wdata;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [31:0] rdata;
    logic        ready;
    logic [17:0] sram_address;
    logic [31:0] sram_wdata;
    logic        sram_r_en;
    logic        sram_w_en;
    logic [63:0] sram_rdata;
    logic        sram_ready;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    sram_cache dut (
        .clk          (clk),
        .rst          (rst_n),
        .address      (address),
        .wdata        (wdata),
        .MEM_R_EN     (mem_r_en),
        .MEM_W_EN     (mem_w_en),
        .rdata        (rdata),
        .ready        (ready),
        .sram_address (sram_address),
        .sram_wdata   (sram_wdata),
        .sram_r_en    (sram_r_en),
        .sram_w_en    (sram_w_en),
        .sram_rdata   (sram_rdata),
        .sram_ready   (sram_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // SRAM controller model: sram_ready pulses after LAT cycles of a strobe.
    initial begin
        int cnt;
        cnt = 0;
        sram_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (sram_ready) begin
                sram_ready = 1'b0;
                cnt = 0;
            end else if (sram_r_en || sram_w_en) begin
                cnt++;
                if (cnt == LAT) sram_ready = 1'b1;
            end else begin
                cnt = 0;
            end
        end
    end

    // Monitor: collect SRAM activity per request, check on completion.
    initial begin
        logic        saw_r;
        logic        saw_w;
        logic [17:0] sa;
        exp_t        e;
        saw_r = 1'b0;
        saw_w = 1'b0;
        sa    = '0;
        forever begin
            @(negedge clk);
            if (!rst_n || !(mem_r_en || mem_w_en)) begin
                saw_r = 1'b0;
                saw_w = 1'b0;
                sa    = '0;
            end else begin
                if (sram_r_en) saw_r = 1'b1;
                if (sram_w_en) saw_w = 1'b1;
                if (sram_r_en || sram_w_en) sa = sram_address;
                if (ready) begin
                    if (sb.size() == 0) begin
                        n_chk++;
                        $display("FAIL unexpected_completion: addr 0x%0h rdata 0x%0h with nothing queued",
                                 address, rdata);
                    end else begin
                        e = sb.pop_front();
                        chk({e.name, "_rdata"}, 64'(rdata), 64'(e.rdata));
                        chk({e.name, "_sram_r_en"}, 64'(saw_r), 64'(e.kind == K_RD));
                        chk({e.name, "_sram_w_en"}, 64'(saw_w), 64'(e.kind == K_WR));
                        if (e.kind != K_HIT) chk({e.name, "_sram_addr"}, 64'(sa), 64'(e.sa));
                    end
                    saw_r = 1'b0;
                    saw_w = 1'b0;
                    sa    = '0;
                end
            end
        end
    end

    // Issue one request at posedge+1 and wait (bounded) for completion.
    task automatic do_req(input string name, input logic [31:0] a, input logic r, input logic w,
                          input logic [31:0] wd, input logic [63:0] blk,
                          input logic [31:0] exp_rd, input int kind, input logic [17:0] exp_sa);
        exp_t e;
        bit   done;
        e.name  = name;
        e.rdata = exp_rd;
        e.kind  = kind;
        e.sa    = exp_sa;
        sb.push_back(e);
        address    = a;
        wdata      = wd;
        sram_rdata = blk;
        mem_r_en   = r;
        mem_w_en   = w;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (ready) done = 1'b1;
        end
        if (!done) begin
            n_chk++;
            $display("FAIL %s_timeout: ready stayed 0 for 20 cycles, expected completion", name);
            sb.delete();
        end
        @(posedge clk);
        #1;
        mem_r_en = 1'b0;
        mem_w_en = 1'b0;
    endtask

    localparam logic [63:0] B0 = 64'h1111_2222_3333_4444;
    localparam logic [63:0] B1 = 64'hA1A1_0001_B1B1_0001;
    localparam logic [63:0] B2 = 64'hA2A2_0002_B2B2_0002;
    localparam logic [63:0] B3 = 64'hA3A3_0003_B3B3_0003;
    localparam logic [63:0] B5 = 64'h5555_6666_7777_8888;

    initial begin
        rst_n      = 1'b0;
        address    = '0;
        wdata      = '0;
        mem_r_en   = 1'b0;
        mem_w_en   = 1'b0;
        sram_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 64'(ready), 64'd1);
        chk("rst_rdata", 64'(rdata), 64'd0);
        chk("rst_sram_r_en", 64'(sram_r_en), 64'd0);
        chk("rst_sram_w_en", 64'(sram_w_en), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Cold miss, then hit on the other word of the filled block.
        do_req("rd_miss_40",  32'h0000_0040, 1, 0, '0, B0, 32'h3333_4444, K_RD,  18'h00040);
        do_req("rd_hit_44",   32'h0000_0044, 1, 0, '0, B0, 32'h1111_2222, K_HIT, 18'h0);
        // Set 8 conflicts: way1<-tag1, way0<-tag2 (evicts tag0), hit tag1, tag3 evicts tag2.
        do_req("rd_miss_1040", 32'h0000_1040, 1, 0, '0, B1, 32'hB1B1_0001, K_RD,  18'h01040);
        do_req("rd_miss_2040", 32'h0000_2040, 1, 0, '0, B2, 32'hB2B2_0002, K_RD,  18'h02040);
        do_req("rd_hit_1040",  32'h0000_1040, 1, 0, '0, B1, 32'hB1B1_0001, K_HIT, 18'h0);
        do_req("rd_miss_3044", 32'h0000_3044, 1, 0, '0, B3, 32'hA3A3_0003, K_RD,  18'h03040);
        do_req("rd_hit_1044",  32'h0000_1044, 1, 0, '0, B1, 32'hA1A1_0001, K_HIT, 18'h0);
        do_req("rd_evicted_2040", 32'h0000_2040, 1, 0, '0, B2, 32'hB2B2_0002, K_RD, 18'h02040);
        // Refill 0x40 (into way1) so the write below hits.
        do_req("rd_refill_40", 32'h0000_0040, 1, 0, '0, B0, 32'h3333_4444, K_RD,  18'h00040);
        do_req("wr_hit_40",    32'h0000_0040, 0, 1, 32'hDEAD_BEEF, '0, 32'h0, K_WR, 18'h00040);
        do_req("rd_after_wr_40", 32'h0000_0040, 1, 0, '0, '0, 32'hDEAD_BEEF, K_HIT, 18'h0);
        do_req("rd_hit_44b",   32'h0000_0044, 1, 0, '0, '0, 32'h1111_2222, K_HIT, 18'h0);
        // Write miss does not allocate.
        do_req("wr_miss_5000", 32'h0000_5000, 0, 1, 32'h1234_5678, '0, 32'h0, K_WR, 18'h05000);
        do_req("rd_miss_5000", 32'h0000_5000, 1, 0, '0, B5, 32'h7777_8888, K_RD,  18'h05000);
        // Both enables: a write, updating the cached high word.
        do_req("rw_both_44",   32'h0000_0044, 1, 1, 32'hCAFE_F00D, '0, 32'h0, K_WR, 18'h00044);
        do_req("rd_after_both_44", 32'h0000_0044, 1, 0, '0, '0, 32'hCAFE_F00D, K_HIT, 18'h0);

        // Reset while in RD abandons the miss and clears all valid bits.
        address    = 32'h0000_7040;
        sram_rdata = B0;
        mem_r_en   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("midrd_sram_r_en_before", 64'(sram_r_en), 64'd1);
        #2;
        mem_r_en = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("midrd_sram_r_en_after", 64'(sram_r_en), 64'd0);
        chk("midrd_ready_after", 64'(ready), 64'd1);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_req("rd_after_rst_40", 32'h0000_0040, 1, 0, '0, B0, 32'h3333_4444, K_RD, 18'h00040);
        do_req("rd_after_rst_44", 32'h0000_0044, 1, 0, '0, B0, 32'h1111_2222, K_HIT, 18'h0);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
